// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module   : fetch_unit_pkg
// Purpose  : Shared types and constants for the instruction fetch stage:
//            FSM state encoding, instruction width and PC increment.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

   localparam int FETCH_STATE_WIDTH = 1;
   localparam int INSTR_WIDTH       = 32;
   localparam int PC_STEP           = 4;

   typedef enum logic [FETCH_STATE_WIDTH-1:0] {
      FETCH_RUN   = 1'b0,
      FETCH_DRAIN = 1'b1
   } fetch_state_e;

endpackage : fetch_unit_pkg

`default_nettype wire

// File: rtl/fetch_unit_sync_fifo.sv
// ============================================================================
// Module   : fetch_unit_sync_fifo
// Purpose  : Single-clock show-ahead FIFO. The head entry is visible on
//            o_data whenever o_empty is low. A push while full is accepted
//            only when a pop happens in the same cycle. i_flush empties the
//            FIFO synchronously and overrides any push/pop in that cycle.
// Ports    : i_clk, i_rst           clock, synchronous active-high reset
//            i_flush                drop all entries
//            i_push, i_data         write side
//            i_pop                  consume head entry
//            o_data                 head entry (show-ahead)
//            o_full, o_empty        status flags
//            o_count                number of stored entries
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q;
   logic [AW-1:0]    wr_ptr_q;
   logic [AW:0]      count_q;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (count_q == '0);
   assign o_full    = (count_q == FULL_COUNT);
   assign o_count   = count_q;
   assign o_data    = mem_q[rd_ptr_q];

   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   // Storage is not reset; only pointers and count carry control meaning.
   always_ff @(posedge i_clk) begin
      if (w_do_push && !i_flush) begin
         mem_q[wr_ptr_q] <= i_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (w_do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (w_do_push && !w_do_pop) begin
            count_q <= count_q + 1'b1;
         end else if (!w_do_push && w_do_pop) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

endmodule : fetch_unit_sync_fifo

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Holds the PC, issues word requests to
//            instruction memory (request/grant, in-order responses of any
//            latency), buffers returned words in a prefetch FIFO and presents
//            {pc, instr} to decode. A redirect from execute flushes the FIFO
//            and drops every response still owed to wrong-path requests.
// Ports    : i_clk, i_rst                 clock, synchronous active-high reset
//            o_imem_req, o_imem_addr      request to instruction memory
//            i_imem_gnt                   request accepted
//            i_imem_rvalid, i_imem_rdata  in-order response word
//            o_valid, o_instr, o_pc       entry presented to decode
//            i_ready                      decode consumes the head entry
//            i_redirect, i_redirect_pc    taken branch/jump target
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
   parameter int                DEPTH    = 2
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   output logic                    o_imem_req,
   output logic [ADDR_W-1:0]       o_imem_addr,
   input  logic                    i_imem_gnt,
   input  logic                    i_imem_rvalid,
   input  logic [INSTR_WIDTH-1:0]  i_imem_rdata,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic [INSTR_WIDTH-1:0]  o_instr,
   output logic [ADDR_W-1:0]       o_pc,
   input  logic                    i_redirect,
   input  logic [ADDR_W-1:0]       i_redirect_pc
);

   localparam int                CNT_W     = $clog2(DEPTH) + 1;
   localparam int                ENT_W     = ADDR_W + INSTR_WIDTH;
   localparam logic [CNT_W:0]    OCC_LIMIT = (CNT_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(PC_STEP);
   localparam logic [ADDR_W-1:0] ALIGN_MSK = ~(ADDR_W'(3));

   fetch_state_e        state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [CNT_W-1:0]    inflight_q, inflight_d;
   logic [CNT_W-1:0]    discard_q, discard_d;

   logic                w_req;
   logic                w_gnt;
   logic                w_rsp;
   logic [CNT_W:0]      w_occupancy;
   logic [ADDR_W-1:0]   w_redirect_pc;
   logic                w_head_valid;

   logic                w_fifo_push;
   logic                w_fifo_pop;
   logic                w_fifo_flush;
   logic                w_fifo_full;
   logic                w_fifo_empty;
   logic [CNT_W-1:0]    w_fifo_count;
   logic [ENT_W-1:0]    w_fifo_wdata;
   logic [ENT_W-1:0]    w_fifo_rdata;

   logic [ADDR_W-1:0]   w_aq_addr;
   logic                w_aq_full;
   logic                w_aq_empty;
   logic [CNT_W-1:0]    w_aq_count;
   logic                w_unused;

   // Words owed by memory plus words buffered never exceed DEPTH, so the
   // FIFO always has room for every response that can arrive.
   assign w_occupancy   = {1'b0, inflight_q} + {1'b0, w_fifo_count};
   assign w_req         = ~i_rst & (state_q == FETCH_RUN) & (w_occupancy < OCC_LIMIT);
   assign w_gnt         = w_req & i_imem_gnt;
   assign w_rsp         = i_imem_rvalid;
   assign w_redirect_pc = i_redirect_pc & ALIGN_MSK;

   assign o_imem_req    = w_req;
   assign o_imem_addr   = i_rst ? RESET_PC : pc_q;

   // Outputs read as the reset values while reset is applied, whatever
   // state the registers were left in.
   assign w_head_valid  = ~i_rst & ~w_fifo_empty;
   assign o_valid       = w_head_valid;
   assign o_pc          = w_head_valid ? w_fifo_rdata[ENT_W-1 -: ADDR_W] : RESET_PC;
   assign o_instr       = w_head_valid ? w_fifo_rdata[INSTR_WIDTH-1:0] : '0;

   // A redirect flushes the FIFO, so a same-cycle pop has no effect.
   assign w_fifo_pop    = w_head_valid & i_ready & ~i_redirect;
   assign w_fifo_wdata  = {w_aq_addr, i_imem_rdata};

   // Address queue: one entry per granted request, retired by its response
   // (kept or discarded), so its head is always the address of the word
   // currently returning.
   fetch_unit_sync_fifo #(
      .WIDTH (ADDR_W),
      .DEPTH (DEPTH)
   ) u_addr_q (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_flush (1'b0),
      .i_push  (w_gnt),
      .i_data  (pc_q),
      .i_pop   (w_rsp),
      .o_data  (w_aq_addr),
      .o_full  (w_aq_full),
      .o_empty (w_aq_empty),
      .o_count (w_aq_count)
   );

   fetch_unit_sync_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_prefetch_q (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_flush (w_fifo_flush),
      .i_push  (w_fifo_push),
      .i_data  (w_fifo_wdata),
      .i_pop   (w_fifo_pop),
      .o_data  (w_fifo_rdata),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   assign w_unused = ^{w_aq_full, w_aq_empty, w_aq_count, w_fifo_full};

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      inflight_d   = inflight_q;
      discard_d    = discard_q;
      w_fifo_push  = 1'b0;
      w_fifo_flush = 1'b0;

      case (state_q)
         FETCH_RUN: begin
            if (w_gnt) begin
               pc_d = pc_q + STEP;
            end
            inflight_d  = inflight_q + CNT_W'(w_gnt) - CNT_W'(w_rsp);
            w_fifo_push = w_rsp & ~i_redirect;
            if (i_redirect) begin
               // Everything still owed after this cycle (including a grant
               // taken right now) belongs to the wrong path.
               w_fifo_flush = 1'b1;
               pc_d         = w_redirect_pc;
               discard_d    = inflight_d;
               if (inflight_d != '0) begin
                  state_d = FETCH_DRAIN;
               end
            end
         end

         FETCH_DRAIN: begin
            if (w_rsp) begin
               inflight_d = inflight_q - CNT_W'(1);
               discard_d  = discard_q - CNT_W'(1);
               if (discard_q == CNT_W'(1)) begin
                  state_d = FETCH_RUN;
               end
            end
            if (i_redirect) begin
               pc_d         = w_redirect_pc;
               w_fifo_flush = 1'b1;
            end
         end

         default: begin
            state_d = FETCH_RUN;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= FETCH_RUN;
         pc_q       <= RESET_PC;
         inflight_q <= '0;
         discard_q  <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
      end
   end

endmodule : fetch_unit

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed self-checking bench for fetch_unit with a small
//            fixed-latency in-order instruction memory model.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

   localparam int          ADDR_W   = 32;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_gnt;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_instr;
   logic [31:0] o_pc;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;

   always #5 i_clk = ~i_clk;

   fetch_unit #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) u_dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_gnt    (i_imem_gnt),
      .i_imem_rvalid (i_imem_rvalid),
      .i_imem_rdata  (i_imem_rdata),
      .o_valid       (o_valid),
      .i_ready       (i_ready),
      .o_instr       (o_instr),
      .o_pc          (o_pc),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t pend[$];
   int    cyc;
   int    mem_lat;
   int    n_total;
   int    n_bad;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return {16'hC0DE, addr[15:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Memory: always grants; returns each granted word mem_lat cycles later.
   task automatic mem_drive();
      pend_t p;
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = 32'h0;
      if (i_rst) begin
         pend.delete();
      end else begin
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = mem_word(pend[0].addr);
            void'(pend.pop_front());
         end
         if (o_imem_req && i_imem_gnt) begin
            p.addr = o_imem_addr;
            p.due  = cyc + mem_lat;
            pend.push_back(p);
         end
      end
   endtask

   // Called just after a falling edge: apply this cycle's inputs.
   task automatic drive(input logic rst, input logic rdy, input logic redir,
                        input logic [31:0] rpc);
      i_rst         = rst;
      i_ready       = rdy;
      i_redirect    = redir;
      i_redirect_pc = rpc;
      i_imem_gnt    = 1'b1;
      #1;
      mem_drive();
      #1;
   endtask

   task automatic next();
      @(posedge i_clk);
      cyc++;
      @(negedge i_clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] exp_pc;
      int          nseen;
      bit          seen;

      i_rst = 1'b1; i_ready = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'h0;
      i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = 32'h0;
      cyc = 0; mem_lat = 1; n_total = 0; n_bad = 0;
      @(negedge i_clk);

      // ---- Reset values, then zero-wait streaming --------------------------
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      check("rst_req",   32'(o_imem_req), 32'd0);
      check("rst_valid", 32'(o_valid),    32'd0);
      check("rst_instr", o_instr,         32'h0);
      check("rst_pc",    o_pc,            RESET_PC);
      check("rst_addr",  o_imem_addr,     RESET_PC);
      next();
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check("a_req0",  32'(o_imem_req), 32'd1);
      check("a_addr0", o_imem_addr,     32'h0);
      next();
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check("a_nobypass", 32'(o_valid), 32'd0);
      check("a_addr1",    o_imem_addr,  32'h4);
      next();
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check("a_valid0", 32'(o_valid),    32'd1);
      check("a_pc0",    o_pc,            32'h0);
      check("a_instr0", o_instr,         32'hC0DE_0000);
      check("a_cap",    32'(o_imem_req), 32'd0);
      next();
      exp_pc = 32'h4;
      nseen  = 0;
      for (int i = 0; i < 12; i++) begin
         drive(1'b0, 1'b1, 1'b0, 32'h0);
         if (o_valid) begin
            check("a_seq_pc",    o_pc,    exp_pc);
            check("a_seq_instr", o_instr, 32'hC0DE_0000 | exp_pc);
            exp_pc = exp_pc + 32'h4;
            nseen++;
         end
         next();
      end
      check("a_seq_cnt", 32'(nseen >= 6), 32'd1);

      // ---- Decode stalled, request throttles, then release -----------------
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      next();
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b0, 1'b0, 32'h0);
         if (i == 1) begin
            check("b_req1",  32'(o_imem_req), 32'd1);
            check("b_addr1", o_imem_addr,     32'h4);
         end
         if (i == 2) check("b_drop", 32'(o_imem_req), 32'd0);
         if (i == 9) begin
            check("b_hold_req",   32'(o_imem_req), 32'd0);
            check("b_hold_valid", 32'(o_valid),    32'd1);
            check("b_hold_pc",    o_pc,            32'h0);
         end
         next();
      end
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check("b_rel_pc0",  o_pc,            32'h0);
      check("b_rel_req0", 32'(o_imem_req), 32'd0);
      next();
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check("b_rel_pc4",   o_pc,            32'h4);
      check("b_rel_instr", o_instr,         32'hC0DE_0004);
      check("b_resume",    32'(o_imem_req), 32'd1);
      check("b_res_addr",  o_imem_addr,     32'h8);
      next();

      // ---- Latency 3, redirect with two words in flight --------------------
      mem_lat = 3;
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      next();
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      next();
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check("c_addr1", o_imem_addr, 32'h4);
      next();
      drive(1'b0, 1'b1, 1'b1, 32'h100);
      check("c_cap", 32'(o_imem_req), 32'd0);
      next();
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check("c_drain1_req",   32'(o_imem_req), 32'd0);
      check("c_drain1_valid", 32'(o_valid),    32'd0);
      next();
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check("c_drain2_req",   32'(o_imem_req), 32'd0);
      check("c_drain2_valid", 32'(o_valid),    32'd0);
      next();
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check("c_new_req",  32'(o_imem_req), 32'd1);
      check("c_new_addr", o_imem_addr,     32'h100);
      next();
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         drive(1'b0, 1'b1, 1'b0, 32'h0);
         if (o_valid) begin
            seen = 1'b1;
            check("c_first_pc",    o_pc,    32'h100);
            check("c_first_instr", o_instr, 32'hC0DE_0100);
         end
         next();
      end
      if (!seen) check("c_timeout", 32'd0, 32'd1);

      // ---- Redirect to unaligned target in the grant cycle -----------------
      mem_lat = 1;
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      next();
      drive(1'b0, 1'b1, 1'b1, 32'h203);
      check("d_gnt_addr", o_imem_addr, 32'h0);
      next();
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check("d_drain_req",   32'(o_imem_req), 32'd0);
      check("d_drain_valid", 32'(o_valid),    32'd0);
      next();
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check("d_req",  32'(o_imem_req), 32'd1);
      check("d_addr", o_imem_addr,     32'h200);
      next();
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check("d_wait_valid", 32'(o_valid), 32'd0);
      next();
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check("d_valid", 32'(o_valid), 32'd1);
      check("d_pc",    o_pc,         32'h200);
      check("d_instr", o_instr,      32'hC0DE_0200);
      next();

      // ---- Redirect, pop and response all in one cycle ---------------------
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      next();
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      next();
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      next();
      drive(1'b0, 1'b1, 1'b1, 32'h300);
      check("e_pre_valid", 32'(o_valid), 32'd1);
      check("e_pre_pc",    o_pc,         32'h0);
      next();
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check("e_flushed", 32'(o_valid),    32'd0);
      check("e_req",     32'(o_imem_req), 32'd1);
      check("e_addr",    o_imem_addr,     32'h300);
      next();
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check("e_no_stale", 32'(o_valid), 32'd0);
      next();
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check("e_new_pc",    o_pc,    32'h300);
      check("e_new_instr", o_instr, 32'hC0DE_0300);
      next();

      // ---- Reset mid-stream with the FIFO full -----------------------------
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      next();
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 1'b0, 32'h0);
         next();
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      check("f_full_valid", 32'(o_valid),    32'd1);
      check("f_full_req",   32'(o_imem_req), 32'd0);
      next();
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      check("f_rst_req",   32'(o_imem_req), 32'd0);
      check("f_rst_valid", 32'(o_valid),    32'd0);
      next();
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      check("f_post_valid", 32'(o_valid),    32'd0);
      check("f_post_pc",    o_pc,            RESET_PC);
      check("f_post_req",   32'(o_imem_req), 32'd1);
      check("f_post_addr",  o_imem_addr,     RESET_PC);
      next();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_fetch_unit

`default_nettype wire
